// File: rtl/pc_muxsel_chk.sv
// F-stage PC mux-select checker: compares pc_f against the selected thread PC, flags bad selects,
// counts errors and halts after MAX_ERR reports. Optional error-history FIFO via PC_MUXSEL_HIST_EN.
module pc_muxsel_chk #(
    parameter int unsigned NUM_THR    = 4,
    parameter int unsigned PC_W       = 48,
    parameter int unsigned WARMUP_CYC = 16,
    parameter int unsigned MAX_ERR    = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic [9:0]              coreid,
    input  logic                    mon_en,
    input  logic                    inst_vld_f,
    input  logic                    dtu_fcl_running_s,
    input  logic [NUM_THR-1:0]      thr_f,
    input  logic [PC_W-1:0]         pc_f,
    input  logic [NUM_THR*PC_W-1:0] tpc_f,
    input  logic                    clr_err,
    output logic                    err_vld,
    output logic [NUM_THR-1:0]      err_thr,
    output logic [PC_W-1:0]         err_act_pc,
    output logic [PC_W-1:0]         err_exp_pc,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    halted,
    input  logic                    hist_rd,
    output logic                    hist_vld,
    output logic [NUM_THR-1:0]      hist_thr,
    output logic [PC_W-1:0]         hist_pc
);

    localparam int unsigned WU_LAST = (WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0;
    localparam int unsigned WU_W    = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int unsigned IDX_W   = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;

    typedef enum logic [1:0] {ST_WARMUP, ST_CHECK, ST_HALT} state_e;

    state_e             state_q, state_d;
    logic [WU_W-1:0]    wu_q, wu_d;
    logic               err_vld_q, err_vld_d;
    logic [NUM_THR-1:0] err_thr_q, err_thr_d;
    logic [PC_W-1:0]    err_act_q, err_act_d;
    logic [PC_W-1:0]    err_exp_q, err_exp_d;
    logic               sel_err_q, sel_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               halted_q, halted_d;

    logic [PC_W-1:0]    exp_pc;
    logic [IDX_W-1:0]   thr_idx;
    logic               thr_found;
    logic               chk_on, qual, thr_zero, thr_multi, pc_mis, err_det, rep_err;

    // Expected PC comes from the lowest set bit of the thread select
    always_comb begin
        exp_pc    = '0;
        thr_idx   = '0;
        thr_found = 1'b0;
        for (int i = 0; i < NUM_THR; i++) begin
            if (!thr_found && thr_f[i]) begin
                thr_found = 1'b1;
                thr_idx   = IDX_W'(i);
                exp_pc    = tpc_f[i*PC_W +: PC_W];
            end
        end
    end

    // Errors are still detected (and counted) in HALT, but only reported in CHECK
    always_comb begin
        chk_on    = (state_q == ST_CHECK) || (state_q == ST_HALT) ||
                    ((state_q == ST_WARMUP) && (WARMUP_CYC == 0));
        qual      = chk_on && inst_vld_f && dtu_fcl_running_s;
        thr_zero  = (thr_f == '0);
        thr_multi = ((thr_f & (thr_f - NUM_THR'(1))) != '0);
        pc_mis    = !thr_zero && (pc_f != exp_pc);
        err_det   = qual && (thr_zero || thr_multi || pc_mis) && !clr_err;
        rep_err   = err_det && (state_q != ST_HALT);
    end

    always_comb begin
        state_d   = state_q;
        wu_d      = wu_q;
        err_vld_d = 1'b0;
        err_thr_d = err_thr_q;
        err_act_d = err_act_q;
        err_exp_d = err_exp_q;
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;

        if (state_q == ST_WARMUP) begin
            if ((WARMUP_CYC == 0) || (wu_q == WU_W'(WU_LAST))) state_d = ST_CHECK;
            else                                               wu_d    = wu_q + WU_W'(1);
        end

        if (err_det) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (thr_zero || thr_multi) sel_err_d = 1'b1;
            if (rep_err) begin
                err_vld_d = 1'b1;
                err_thr_d = thr_f;
                err_act_d = pc_f;
                err_exp_d = exp_pc;
                if (err_cnt_d >= CNT_W'(MAX_ERR)) state_d = ST_HALT;
            end
        end

        if (clr_err) begin
            err_cnt_d = '0;
            sel_err_d = 1'b0;
            if (state_q == ST_HALT) state_d = ST_CHECK;
        end

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_WARMUP;
            wu_q      <= '0;
            err_vld_q <= 1'b0;
            err_thr_q <= '0;
            err_act_q <= '0;
            err_exp_q <= '0;
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wu_q      <= wu_d;
            err_vld_q <= err_vld_d;
            err_thr_q <= err_thr_d;
            err_act_q <= err_act_d;
            err_exp_q <= err_exp_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
            halted_q  <= halted_d;
        end
    end

    assign err_vld    = err_vld_q;
    assign err_thr    = err_thr_q;
    assign err_act_pc = err_act_q;
    assign err_exp_pc = err_exp_q;
    assign sel_err    = sel_err_q;
    assign err_cnt    = err_cnt_q;
    assign halted     = halted_q;

`ifndef SYNTHESIS
    // Simulation-only report of each reported error
    always_ff @(posedge clk) begin
        if (rst_l && rep_err) begin
            if (mon_en) begin
                $display("Error -> %0t core %0d: pc mux-select error thr=%0d act=0x%0h exp=0x%0h",
                         $time, coreid, thr_idx, pc_f, exp_pc);
            end else begin
                $display("Warning -> %0t core %0d: pc mux-select error thr=%0d act=0x%0h exp=0x%0h",
                         $time, coreid, thr_idx, pc_f, exp_pc);
            end
        end
    end
`endif

`ifdef PC_MUXSEL_HIST_EN
    localparam int unsigned HD_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int unsigned HC_W = $clog2(HIST_DEPTH + 1);

    logic [NUM_THR-1:0] hthr_q [HIST_DEPTH];
    logic [NUM_THR-1:0] hthr_d [HIST_DEPTH];
    logic [PC_W-1:0]    hpc_q  [HIST_DEPTH];
    logic [PC_W-1:0]    hpc_d  [HIST_DEPTH];
    logic [HD_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [HC_W-1:0]    hcnt_q, hcnt_d;
    logic               hvld_q, hvld_d;
    logic [NUM_THR-1:0] hhead_thr_q, hhead_thr_d;
    logic [PC_W-1:0]    hhead_pc_q, hhead_pc_d;
    logic               push, pop, full;

    function automatic logic [HD_W-1:0] ptr_inc(input logic [HD_W-1:0] p);
        return (p == HD_W'(HIST_DEPTH - 1)) ? '0 : p + HD_W'(1);
    endfunction

    // A push into a full FIFO also advances the read pointer, dropping the oldest entry
    always_comb begin
        hthr_d = hthr_q;
        hpc_d  = hpc_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        hcnt_d = hcnt_q;
        push   = rep_err;
        pop    = hist_rd && (hcnt_q != '0);
        full   = (hcnt_q == HC_W'(HIST_DEPTH));
        if (clr_err) begin
            wr_d   = '0;
            rd_d   = '0;
            hcnt_d = '0;
        end else begin
            if (push) begin
                hthr_d[wr_q] = thr_f;
                hpc_d[wr_q]  = pc_f;
                wr_d         = ptr_inc(wr_q);
            end
            if (pop || (push && full)) rd_d = ptr_inc(rd_q);
            if (push && !pop && !full) hcnt_d = hcnt_q + HC_W'(1);
            else if (pop && !push)     hcnt_d = hcnt_q - HC_W'(1);
        end
        hvld_d      = (hcnt_d != '0);
        hhead_thr_d = hvld_d ? hthr_d[rd_d] : '0;
        hhead_pc_d  = hvld_d ? hpc_d[rd_d]  : '0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hthr_q[i] <= '0;
                hpc_q[i]  <= '0;
            end
            wr_q        <= '0;
            rd_q        <= '0;
            hcnt_q      <= '0;
            hvld_q      <= 1'b0;
            hhead_thr_q <= '0;
            hhead_pc_q  <= '0;
        end else begin
            hthr_q      <= hthr_d;
            hpc_q       <= hpc_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            hcnt_q      <= hcnt_d;
            hvld_q      <= hvld_d;
            hhead_thr_q <= hhead_thr_d;
            hhead_pc_q  <= hhead_pc_d;
        end
    end

    assign hist_vld = hvld_q;
    assign hist_thr = hhead_thr_q;
    assign hist_pc  = hhead_pc_q;
`else
    logic unused_hist;
    assign unused_hist = hist_rd ^ (HIST_DEPTH == 0);
    assign hist_vld    = 1'b0;
    assign hist_thr    = '0;
    assign hist_pc     = '0;
`endif

endmodule
